// File: rtl/demux_buf_if.sv
// demux_buf_if: bundles the source-side and both consumer-side handshakes of
// the buffered 1-to-2 demultiplexer.
//   master modport : producer/consumer side (drives In/Sel/In_valid, OutN_ready)
//   slave  modport : demux side (drives In_ready, OutN, OutN_valid, OutN_count)
interface demux_buf_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
);
   logic [WIDTH-1:0] In;
   logic             Sel;
   logic             In_valid;
   logic             In_ready;
   logic [WIDTH-1:0] Out1;
   logic             Out1_valid;
   logic             Out1_ready;
   logic [CW-1:0]    Out1_count;
   logic [WIDTH-1:0] Out2;
   logic             Out2_valid;
   logic             Out2_ready;
   logic [CW-1:0]    Out2_count;

   modport master (
      output In, Sel, In_valid, Out1_ready, Out2_ready,
      input  In_ready, Out1, Out1_valid, Out1_count, Out2, Out2_valid, Out2_count
   );

   modport slave (
      input  In, Sel, In_valid, Out1_ready, Out2_ready,
      output In_ready, Out1, Out1_valid, Out1_count, Out2, Out2_valid, Out2_count
   );
endinterface

// File: rtl/demux_buf.sv
// demux_buf: buffered 1-to-2 demultiplexer. Each incoming word is routed by
// Sel (1 -> Out1, 0 -> Out2) into a per-destination flop FIFO with its own
// valid/ready handshake, so a stalled consumer never blocks the other path.
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset, wins over any push/pop
//   bus  : demux_buf_if.slave (In/Sel/In_valid/In_ready, OutN/OutN_valid/
//          OutN_ready/OutN_count for N = 1, 2)

// Per-destination FIFO lane. Push is pre-qualified by the top level.
module demux_buf_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [CW-1:0]    o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic [AW-1:0]               r_wptr;
   logic [AW-1:0]               r_rptr;
   logic [CW-1:0]               r_count;
   logic                        w_pop;

   // Popping an empty FIFO is ignored so the count cannot underflow.
   assign w_pop   = i_ready && (r_count != '0);
   assign o_valid = (r_count != '0);
   assign o_count = r_count;
   // Head reads as zero while empty; storage may hold stale words.
   assign o_data  = o_valid ? r_mem[r_rptr] : '0;

   // Storage has no reset: contents are don't-care when count is 0.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   // Pointers wrap naturally (DEPTH is a power of two); full/empty come from count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module demux_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   demux_buf_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   // Lane 0 serves Out1 (Sel = 1), lane 1 serves Out2 (Sel = 0).
   logic [1:0]            w_push;
   logic [1:0]            w_ready;
   logic [1:0][WIDTH-1:0] w_data;
   logic [1:0]            w_valid;
   logic [1:0][CW-1:0]    w_count;
   logic                  w_accept;

   // Full FIFOs refuse input even if they pop this cycle: In_ready depends
   // only on registered counts, keeping the path from OutN_ready to In_ready open.
   assign bus.In_ready = !rst && (bus.Sel ? (w_count[0] < CW'(DEPTH))
                                          : (w_count[1] < CW'(DEPTH)));
   assign w_accept     = bus.In_valid && bus.In_ready;
   assign w_push       = {w_accept && !bus.Sel, w_accept && bus.Sel};
   assign w_ready      = {bus.Out2_ready, bus.Out1_ready};

   for (genvar g = 0; g < 2; g++) begin : g_lane
      demux_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_push  (w_push[g]),
         .i_data  (bus.In),
         .i_ready (w_ready[g]),
         .o_data  (w_data[g]),
         .o_valid (w_valid[g]),
         .o_count (w_count[g])
      );
   end

   assign bus.Out1       = w_data[0];
   assign bus.Out1_valid = w_valid[0];
   assign bus.Out1_count = w_count[0];
   assign bus.Out2       = w_data[1];
   assign bus.Out2_valid = w_valid[1];
   assign bus.Out2_count = w_count[1];
endmodule

// File: tb/tb_demux_buf.sv
module tb_demux_buf;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   demux_buf_if #(.WIDTH(8), .DEPTH(4)) bus ();

   demux_buf #(.WIDTH(8), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Advance one edge, then settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pure stimulus: one-cycle push, caller guarantees In_ready.
   task automatic push(input logic sel, input logic [7:0] data);
      bus.In = data; bus.Sel = sel; bus.In_valid = 1'b1;
      tick();
      bus.In_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.In = 8'hEE; bus.Sel = 1'b1; bus.In_valid = 1'b1;
      bus.Out1_ready = 1'b0; bus.Out2_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         @(negedge clk);
         n_total += 6;
         if (bus.In_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready c=%0d got=%b exp=0", c, bus.In_ready); end
         if (bus.Out1_valid !== 1'b0) begin n_bad++; $display("FAIL rst_v1 got=%b exp=0", bus.Out1_valid); end
         if (bus.Out2_valid !== 1'b0) begin n_bad++; $display("FAIL rst_v2 got=%b exp=0", bus.Out2_valid); end
         if (bus.Out1_count !== 3'd0) begin n_bad++; $display("FAIL rst_c1 got=%0d exp=0", bus.Out1_count); end
         if (bus.Out2_count !== 3'd0) begin n_bad++; $display("FAIL rst_c2 got=%0d exp=0", bus.Out2_count); end
         if ({bus.Out1, bus.Out2} !== 16'h0) begin n_bad++; $display("FAIL rst_data got=%h/%h exp=0/0", bus.Out1, bus.Out2); end
      end
      tick();
      rst = 1'b0; bus.In_valid = 1'b0;
      tick();
      @(negedge clk);
      n_total += 2;
      if (bus.Out1_count !== 3'd0) begin n_bad++; $display("FAIL rst_nocap1 got=%0d exp=0", bus.Out1_count); end
      if (bus.In_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after got=%b exp=1", bus.In_ready); end
      tick();
   endtask

   task automatic test_routing();
      bus.Out1_ready = 1'b1; bus.Out2_ready = 1'b1;
      bus.In = 8'hA5; bus.Sel = 1'b1; bus.In_valid = 1'b1;
      @(negedge clk);
      n_total += 2;
      if (bus.In_ready !== 1'b1) begin n_bad++; $display("FAIL route_ready got=%b exp=1", bus.In_ready); end
      // No same-cycle bypass.
      if (bus.Out1_valid !== 1'b0) begin n_bad++; $display("FAIL route_nobypass got=%b exp=0", bus.Out1_valid); end
      tick();
      bus.In = 8'h3C; bus.Sel = 1'b0;
      @(negedge clk);
      n_total += 3;
      if (bus.Out1 !== 8'hA5) begin n_bad++; $display("FAIL route_out1 got=%h exp=a5", bus.Out1); end
      if (bus.Out1_valid !== 1'b1) begin n_bad++; $display("FAIL route_v1 got=%b exp=1", bus.Out1_valid); end
      if (bus.Out2_valid !== 1'b0) begin n_bad++; $display("FAIL route_v2_pre got=%b exp=0", bus.Out2_valid); end
      tick();
      bus.In_valid = 1'b0;
      @(negedge clk);
      n_total += 3;
      if (bus.Out2 !== 8'h3C) begin n_bad++; $display("FAIL route_out2 got=%h exp=3c", bus.Out2); end
      if (bus.Out1_count !== 3'd0) begin n_bad++; $display("FAIL route_c1 got=%0d exp=0", bus.Out1_count); end
      if (bus.Out1 !== 8'h00) begin n_bad++; $display("FAIL route_out1_empty got=%h exp=00", bus.Out1); end
      tick();
      @(negedge clk);
      n_total += 1;
      if (bus.Out2_count !== 3'd0) begin n_bad++; $display("FAIL route_c2 got=%0d exp=0", bus.Out2_count); end
      tick();
   endtask

   task automatic test_fill_block();
      bus.Out1_ready = 1'b0; bus.Out2_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(1'b1, 8'(i));
      bus.Sel = 1'b1;
      @(negedge clk);
      n_total += 3;
      if (bus.Out1_count !== 3'd4) begin n_bad++; $display("FAIL fill_c1 got=%0d exp=4", bus.Out1_count); end
      if (bus.Out1 !== 8'h01) begin n_bad++; $display("FAIL fill_head got=%h exp=01", bus.Out1); end
      if (bus.In_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_sel1 got=%b exp=0", bus.In_ready); end
      bus.Sel = 1'b0;
      #1;
      n_total += 1;
      if (bus.In_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_sel0 got=%b exp=1", bus.In_ready); end
      tick();
      push(1'b0, 8'h77);
      @(negedge clk);
      n_total += 3;
      if (bus.Out2 !== 8'h77) begin n_bad++; $display("FAIL fill_out2 got=%h exp=77", bus.Out2); end
      if (bus.Out2_count !== 3'd1) begin n_bad++; $display("FAIL fill_c2 got=%0d exp=1", bus.Out2_count); end
      if (bus.Out1 !== 8'h01) begin n_bad++; $display("FAIL fill_hold got=%h exp=01", bus.Out1); end
      tick();
      bus.Out1_ready = 1'b1; bus.Out2_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_total += 1;
         if (bus.Out1 !== 8'(k) || bus.Out1_valid !== 1'b1) begin
            n_bad++; $display("FAIL fill_drain k=%0d got=%h/%b exp=%h/1", k, bus.Out1, bus.Out1_valid, 8'(k));
         end
         tick();
      end
      @(negedge clk);
      n_total += 2;
      if (bus.Out1_count !== 3'd0) begin n_bad++; $display("FAIL fill_c1_end got=%0d exp=0", bus.Out1_count); end
      if (bus.Out2_count !== 3'd0) begin n_bad++; $display("FAIL fill_c2_end got=%0d exp=0", bus.Out2_count); end
      tick();
   endtask

   task automatic test_wrap();
      int pushed = 0;
      int popped = 0;
      int cyc    = 0;
      bus.Sel = 1'b0; bus.Out1_ready = 1'b0;
      while (popped < 10 && cyc < 100) begin
         bus.In = 8'h10 + 8'(pushed);
         bus.In_valid = (pushed < 10);
         bus.Out2_ready = (cyc % 2 == 0);
         @(negedge clk);
         n_total += 1;
         if (bus.Out2_count > 3'd4) begin n_bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp<=4", cyc, bus.Out2_count); end
         if (bus.Out2_valid && bus.Out2_ready) begin
            n_total += 1;
            if (bus.Out2 !== 8'h10 + 8'(popped)) begin
               n_bad++; $display("FAIL wrap_seq i=%0d got=%h exp=%h", popped, bus.Out2, 8'h10 + 8'(popped));
            end
            popped++;
         end
         if (bus.In_valid && bus.In_ready) pushed++;
         tick();
         cyc++;
      end
      bus.In_valid = 1'b0; bus.Out2_ready = 1'b0;
      @(negedge clk);
      n_total += 2;
      if (popped != 10) begin n_bad++; $display("FAIL wrap_timeout popped=%0d exp=10", popped); end
      if (bus.Out2_count !== 3'd0) begin n_bad++; $display("FAIL wrap_c2_end got=%0d exp=0", bus.Out2_count); end
      tick();
   endtask

   task automatic test_full_pop();
      bus.Out1_ready = 1'b0; bus.Out2_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(1'b0, 8'h21 + 8'(i));
      bus.In = 8'h25; bus.Sel = 1'b0; bus.In_valid = 1'b1; bus.Out2_ready = 1'b1;
      @(negedge clk);
      n_total += 2;
      if (bus.In_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", bus.In_ready); end
      if (bus.Out2_count !== 3'd4) begin n_bad++; $display("FAIL full_c2 got=%0d exp=4", bus.Out2_count); end
      tick();
      bus.Out2_ready = 1'b0;
      @(negedge clk);
      n_total += 3;
      if (bus.Out2_count !== 3'd3) begin n_bad++; $display("FAIL full_c2_pop got=%0d exp=3", bus.Out2_count); end
      if (bus.In_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready2 got=%b exp=1", bus.In_ready); end
      if (bus.Out2 !== 8'h22) begin n_bad++; $display("FAIL full_head got=%h exp=22", bus.Out2); end
      tick();
      bus.In_valid = 1'b0;
      @(negedge clk);
      n_total += 1;
      if (bus.Out2_count !== 3'd4) begin n_bad++; $display("FAIL full_c2_refill got=%0d exp=4", bus.Out2_count); end
      tick();
      bus.Out2_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_total += 1;
         if (bus.Out2 !== 8'h22 + 8'(k)) begin n_bad++; $display("FAIL full_drain k=%0d got=%h exp=%h", k, bus.Out2, 8'h22 + 8'(k)); end
         tick();
      end
      bus.Out2_ready = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      bus.Out1_ready = 1'b0; bus.Out2_ready = 1'b0;
      push(1'b1, 8'h31); push(1'b1, 8'h32); push(1'b1, 8'h33);
      push(1'b0, 8'h41); push(1'b0, 8'h42);
      @(negedge clk);
      n_total += 2;
      if (bus.Out1_count !== 3'd3) begin n_bad++; $display("FAIL mrst_pre_c1 got=%0d exp=3", bus.Out1_count); end
      if (bus.Out2_count !== 3'd2) begin n_bad++; $display("FAIL mrst_pre_c2 got=%0d exp=2", bus.Out2_count); end
      tick();
      rst = 1'b1; bus.In = 8'hFF; bus.Sel = 1'b1; bus.In_valid = 1'b1;
      @(negedge clk);
      n_total += 1;
      if (bus.In_ready !== 1'b0) begin n_bad++; $display("FAIL mrst_ready got=%b exp=0", bus.In_ready); end
      tick();
      rst = 1'b0; bus.In_valid = 1'b0;
      @(negedge clk);
      n_total += 4;
      if (bus.Out1_count !== 3'd0) begin n_bad++; $display("FAIL mrst_c1 got=%0d exp=0", bus.Out1_count); end
      if (bus.Out2_count !== 3'd0) begin n_bad++; $display("FAIL mrst_c2 got=%0d exp=0", bus.Out2_count); end
      if ({bus.Out1_valid, bus.Out2_valid} !== 2'b00) begin n_bad++; $display("FAIL mrst_valid got=%b%b exp=00", bus.Out1_valid, bus.Out2_valid); end
      if (bus.Out1 !== 8'h00) begin n_bad++; $display("FAIL mrst_out1 got=%h exp=00", bus.Out1); end
      tick();
      push(1'b1, 8'h42);
      @(negedge clk);
      n_total += 2;
      if (bus.Out1 !== 8'h42) begin n_bad++; $display("FAIL mrst_first got=%h exp=42", bus.Out1); end
      if (bus.Out1_count !== 3'd1) begin n_bad++; $display("FAIL mrst_c1_after got=%0d exp=1", bus.Out1_count); end
      tick();
      bus.Out1_ready = 1'b1;
      tick();
      bus.Out1_ready = 1'b0;
   endtask

   initial begin
      bus.In = '0; bus.Sel = 1'b0; bus.In_valid = 1'b0;
      bus.Out1_ready = 1'b0; bus.Out2_ready = 1'b0;
      test_reset();
      test_routing();
      test_fill_block();
      test_wrap();
      test_full_pop();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
